memory_reader: RTL and testbench

Sequential read-out engine for the keyboard register file. On a `start` pulse it sweeps the file's combinational read port from address 0 to `NUM_REGS-1`, registers each word, and streams it downstream over a valid/ready handshake to the display or serial path. It raises `done` when the sweep completes. It is the read-side counterpart to the write path that fills the register file from keystrokes.

---
 rtl/memory_reader.sv | 140 ++++++++++++++
 tb/tb_memory_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// memory_reader: sweeps a register file's combinational read port from
// address 0 to NUM_REGS-1 and streams each word downstream with its index.
// Optional build macro: MEMORY_READER_SKIP_BLANK_EN drops entries that hold
// the BLANK fill value instead of presenting them.
//
// Handshake: out_valid/out_data/out_index are registered and stay stable
// while out_valid=1; a word transfers on a rising edge where
// out_valid & out_ready, and out_valid never depends on out_ready in the
// same cycle.
module memory_reader #(
    parameter int              NUM_REGS = 16,
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] BLANK    = SIZE'(32'h150)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [5:0]      rd_addr,
    input  logic [SIZE-1:0] rd_data,
    output logic [SIZE-1:0] out_data,
    output logic [5:0]      out_index,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ADDR = 6'(NUM_REGS - 1);

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [SIZE-1:0] data_q, data_d;
    logic [5:0]      index_q, index_d;
    logic            valid_q, valid_d;
    logic            last_addr;

    assign last_addr = (cnt_q == LAST_ADDR);

`ifdef MEMORY_READER_SKIP_BLANK_EN
    logic fetch_blank;
    assign fetch_blank = (rd_data == BLANK);
`else
    // BLANK only matters when blank skipping is built in.
    logic unused_blank;
    assign unused_blank = ^BLANK;
`endif

    // State, counter and output-word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: fetch one word, hold it until accepted, advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
`ifdef MEMORY_READER_SKIP_BLANK_EN
                if (fetch_blank) begin
                    // Blank entry: spend this cycle only, present nothing.
                    if (last_addr) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    data_d  = rd_data;
                    index_d = cnt_q;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
`else
                data_d  = rd_data;
                index_d = cnt_q;
                valid_d = 1'b1;
                state_d = SEND;
`endif
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (last_addr) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The read address is only meaningful while fetching; park it at 0 otherwise.
    assign rd_addr   = (state_q == FETCH) ? cnt_q : 6'd0;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_reader.sv
// Self-checking bench for memory_reader: a behavioural register file drives
// rd_data, directed sweeps push expected {index,data} words into a queue and
// a negedge monitor pops and compares on every transfer.
module tb_memory_reader;

    localparam int          NUM_REGS = 16;
    localparam int          SIZE     = 32;
    localparam logic [31:0] BLANK    = 32'h150;

    logic            clk;
    logic            rst;
    logic            start;
    logic [5:0]      rd_addr;
    logic [SIZE-1:0] rd_data;
    logic [SIZE-1:0] out_data;
    logic [5:0]      out_index;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    logic [SIZE-1:0] mem [64];
    logic [37:0]     exp_q [$];
    logic [37:0]     exp_word;

    int n_checks;
    int n_fail;
    int n_xfer;
    int bp_hold;
    int cyc;
    int dones;

    memory_reader #(.NUM_REGS(NUM_REGS), .SIZE(SIZE), .BLANK(BLANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Combinational register-file read port.
    assign rd_data = mem[rd_addr];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got index %0d data %0h, expected no word",
                         out_index, out_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("sb_word", {out_index, out_data}, exp_word);
            end
        end
    end

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + 32'(i);
    endtask

    task automatic push_file();
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef MEMORY_READER_SKIP_BLANK_EN
            if (mem[i] != BLANK) exp_q.push_back({6'(i), mem[i]});
`else
            exp_q.push_back({6'(i), mem[i]});
`endif
        end
    endtask

    // mode 0: plain, 1: backpressure on word 3, 2: start pulse at word 7,
    // 3: live write of address 10 while word 2 is presented.
    task automatic run_sweep(input int mode);
        int  c;
        int  hold;
        bit  pulsed;
        cyc    = -1;
        dones  = 0;
        hold   = 0;
        pulsed = 1'b0;
        n_xfer = 0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        check("busy_after_start", {37'd0, busy}, 38'd1);
        while (c < 300 && !(cyc >= 0 && c >= cyc + 20)) begin
            @(posedge clk); #1;
            c++;
            if (done) begin
                dones++;
                if (cyc < 0) cyc = c;
            end
            case (mode)
                1: begin
                    if (out_valid && out_index == 6'd3 && hold < 5) begin
                        check("bp_data",  {6'd0, out_data}, {6'd0, 32'hA3});
                        check("bp_index", {32'd0, out_index}, 38'd3);
                        check("bp_valid", {37'd0, out_valid}, 38'd1);
                        out_ready = 1'b0;
                        hold++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                2: begin
                    if (out_valid && out_index == 6'd7 && !pulsed) begin
                        start  = 1'b1;
                        pulsed = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                end
                3: begin
                    if (out_valid && out_index == 6'd2) mem[10] = 32'h55;
                end
                default: ;
            endcase
        end
        if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected one", c);
        end
        bp_hold   = hold;
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_xfer    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = BLANK;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  {37'd0, out_valid}, 38'd0);
        check("rst_busy",   {37'd0, busy},      38'd0);
        check("rst_done",   {37'd0, done},      38'd0);
        check("rst_rdaddr", {32'd0, rd_addr},   38'd0);
        check("rst_data",   {6'd0, out_data},   38'd0);
        check("rst_index",  {32'd0, out_index}, 38'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset sweep over an all-blank file.
        push_file();
        run_sweep(0);
        check("blank_dones", 38'(dones), 38'd1);
        check("blank_sbempty", 38'(exp_q.size()), 38'd0);
`ifdef MEMORY_READER_SKIP_BLANK_EN
        check("blank_xfers", 38'(n_xfer), 38'd0);
`else
        check("blank_xfers", 38'(n_xfer), 38'd16);
        check("blank_cycles", 38'(cyc), 38'd32);
`endif
        check("blank_idle_busy", {37'd0, busy}, 38'd0);

        // Backpressure on word 3 for 5 cycles.
        fill_ramp();
        push_file();
        run_sweep(1);
        check("bp_hold_cnt", 38'(bp_hold), 38'd5);
        check("bp_cycles", 38'(cyc), 38'd37);
        check("bp_dones", 38'(dones), 38'd1);
        check("bp_xfers", 38'(n_xfer), 38'd16);

        // Start pulse while word 7 is presented is ignored.
        push_file();
        run_sweep(2);
        check("ign_cycles", 38'(cyc), 38'd32);
        check("ign_dones", 38'(dones), 38'd1);
        check("ign_xfers", 38'(n_xfer), 38'd16);
        check("ign_busy", {37'd0, busy}, 38'd0);

        // Reset while word 9 is held in SEND.
        push_file();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int w;
            w = 0;
            while (!(out_valid && out_index == 6'd9) && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            check("mid_reach9", {32'd0, out_index}, 38'd9);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_valid",  {37'd0, out_valid}, 38'd0);
        check("mid_busy",   {37'd0, busy},      38'd0);
        check("mid_rdaddr", {32'd0, rd_addr},   38'd0);
        check("mid_done",   {37'd0, done},      38'd0);
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_done_after", {37'd0, done}, 38'd0);
        push_file();
        run_sweep(0);
        check("restart_cycles", 38'(cyc), 38'd32);
        check("restart_xfers", 38'(n_xfer), 38'd16);

        // Live write of address 10 while word 2 is presented.
        fill_ramp();
        push_file();
        exp_q[10] = {6'd10, 32'h55};
        run_sweep(3);
        check("live_dones", 38'(dones), 38'd1);
        check("live_xfers", 38'(n_xfer), 38'd16);

`ifdef MEMORY_READER_SKIP_BLANK_EN
        // Only addresses 0, 5 and 15 hold data.
        for (int i = 0; i < 64; i++) mem[i] = BLANK;
        mem[0]  = 32'd1;
        mem[5]  = 32'd2;
        mem[15] = 32'd3;
        exp_q.push_back({6'd0, 32'd1});
        exp_q.push_back({6'd5, 32'd2});
        exp_q.push_back({6'd15, 32'd3});
        run_sweep(0);
        check("skip_xfers", 38'(n_xfer), 38'd3);
        check("skip_dones", 38'(dones), 38'd1);
`endif

        check("final_sbempty", 38'(exp_q.size()), 38'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
